// File: rtl/mov_pipe.sv
// mov_pipe: elastic DEPTH-stage register pipeline with valid/ready handshakes.
// Words move unchanged and in order, one per cycle at full throughput.
// Empty stages collapse while the output is stalled, and a synchronous flush
// drops every held word.
// Optional feature macro: MOV_PIPE_OCC_EN adds the registered occupancy
// output 'occ', which counts the stages that currently hold a word.
module mov_pipe #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data
`ifdef MOV_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  // Per-stage valid flags and data registers.
  logic [DEPTH-1:0] vld;
  logic [N-1:0]     dat [DEPTH];

  // rdy[i] is high when stage i may load this cycle. rdy[DEPTH] is the consumer.
  logic [DEPTH:0]   rdy;

  // Source of each stage: the input port for stage 0, the stage before it otherwise.
  logic [DEPTH-1:0] src_vld;
  logic [N-1:0]     src_dat [DEPTH];

  // Ready chain. The running 'chain' variable avoids a combinational self-loop on rdy.
  always_comb begin
    logic chain;
    rdy        = '0;
    chain      = out_ready;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = !vld[i] || chain;
      rdy[i] = chain;
    end
  end

  // Select the word and valid flag that each stage takes when it loads.
  always_comb begin
    src_vld    = '0;
    src_vld[0] = in_valid;
    src_dat[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_vld[i] = vld[i-1];
      src_dat[i] = dat[i-1];
    end
  end

  // A flush blocks both handshakes for the cycle in which it is asserted.
  assign in_ready  = rdy[0] && !flush;
  assign out_valid = vld[DEPTH-1] && !flush;
  assign out_data  = dat[DEPTH-1];

  // Valid flags advance on ready. A flush clears all of them, and so does reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld[i] <= src_vld[i];
        end
      end
    end
  end

  // Data registers load only when a real word arrives, so bubbles cause no toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
      end
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i] && src_vld[i]) begin
          dat[i] <= src_dat[i];
        end
      end
    end
  end

`ifdef MOV_PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // The occupancy counter follows the transfers. It equals the number of set valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end
`endif

endmodule
